// File: rtl/stopwatch_pkg.sv
// Shared types and digit-radix helpers for the up/down stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sw_state_t;

  localparam int RADIX_DEC      = 10;
  localparam int RADIX_SEC_TENS = 6;

  // Digit 2 holds tens of seconds; every other digit is decimal.
  function automatic int digit_radix(input int idx);
    if (idx == 2) begin
      digit_radix = RADIX_SEC_TENS;
    end else begin
      digit_radix = RADIX_DEC;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One mixed-radix counter digit with ripple carry/borrow and saturating load.
module bcd_digit_cell
  import stopwatch_pkg::*;
#(
  parameter int RADIX = RADIX_DEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_cin,
  input  logic       i_bin,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [3:0] o_digit,
  output logic       o_cout,
  output logic       o_bout
);

  localparam logic [3:0] MAXV = 4'(RADIX - 1);

  logic [3:0] r_digit;
  logic [3:0] w_sat;

  // Out-of-range preload digits clamp to the largest legal value.
  always_comb begin
    if (i_load_val > MAXV) begin
      w_sat = MAXV;
    end else begin
      w_sat = i_load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= w_sat;
    end else if (i_inc && i_cin) begin
      r_digit <= (r_digit == MAXV) ? 4'd0 : r_digit + 4'd1;
    end else if (i_dec && i_bin) begin
      r_digit <= (r_digit == 4'd0) ? MAXV : r_digit - 4'd1;
    end
  end

  assign o_digit = r_digit;
  assign o_cout  = i_cin & (r_digit == MAXV);
  assign o_bout  = i_bin & (r_digit == 4'd0);

endmodule

// File: rtl/stopwatch_updown_gen.sv
// Up/down stopwatch / countdown timer with run FSM, preload and expiry.
// Optional lap hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_updown_gen
  import stopwatch_pkg::*;
#(
  parameter int DVSR       = 10000000,
  parameter int MIN_DIGITS = 1,
  parameter int WRAP_DOWN  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clr,
  input  logic                        dir,
  input  logic                        load,
  input  logic [4*(MIN_DIGITS+3)-1:0] load_val,
  input  logic                        lap,
  output logic [4*(MIN_DIGITS+3)-1:0] digits,
  output logic                        running,
  output logic                        tick,
  output logic                        wrap,
  output logic                        expired
);

  localparam int   NDIG    = MIN_DIGITS + 3;
  localparam int   CW      = 4 * NDIG;
  localparam int   PW      = $clog2(DVSR);
  localparam logic WRAP_EN = (WRAP_DOWN != 0);

  sw_state_t      r_state;
  sw_state_t      w_state_nxt;
  logic [PW-1:0]  r_presc;
  logic           r_wrap;
  logic           r_expired;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_cell_val;
  logic [NDIG:0]  w_carry;
  logic [NDIG:0]  w_borrow;
  logic           w_tick;
  logic           w_inc;
  logic           w_dec;
  logic           w_all_zero;
  logic           w_is_one;
  logic           w_expire;
  logic           w_wrap_ev;
  logic           w_cell_load;

  assign w_tick      = (r_state == RUN) && (r_presc == PW'(DVSR - 1));
  assign w_all_zero  = (w_count == {CW{1'b0}});
  assign w_is_one    = (w_count == {{(CW-4){1'b0}}, 4'd1});
  assign w_cell_load = clr | load;
  assign w_cell_val  = clr ? {CW{1'b0}} : load_val;

  // Without down-wrap a zero count must not borrow; the tick is absorbed as expiry.
  assign w_inc     = w_tick & ~dir;
  assign w_dec     = w_tick & dir & (WRAP_EN | ~w_all_zero);
  assign w_expire  = w_tick & dir & ~WRAP_EN & (w_all_zero | w_is_one);
  assign w_wrap_ev = (w_inc & w_carry[NDIG]) | (w_dec & w_borrow[NDIG]);

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_cell #(
      .RADIX(digit_radix(g))
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .i_cin      (w_carry[g]),
      .i_bin      (w_borrow[g]),
      .i_load     (w_cell_load),
      .i_load_val (w_cell_val[4*g +: 4]),
      .o_digit    (w_count[4*g +: 4]),
      .o_cout     (w_carry[g+1]),
      .o_bout     (w_borrow[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority clr > load > stop > start; expiry outranks a coincident stop.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cell_load) begin
      if (r_state == DONE) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (stop) begin
            w_state_nxt = IDLE;
          end else if (start) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          if (w_expire) begin
            w_state_nxt = DONE;
          end else if (stop) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RUN;
          end
        end
        DONE: begin
          if (!stop && start && !w_all_zero) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (r_state == RUN);
    tick    = w_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= {PW{1'b0}};
    end else if (w_cell_load) begin
      r_presc <= {PW{1'b0}};
    end else if (r_state == RUN) begin
      r_presc <= w_tick ? {PW{1'b0}} : r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Wrap pulse and sticky expiry line up with the updated count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_wrap <= w_wrap_ev & ~w_cell_load;
      if (w_cell_load) begin
        r_expired <= 1'b0;
      end else if (w_expire) begin
        r_expired <= 1'b1;
      end
    end
  end

  assign wrap    = r_wrap;
  assign expired = r_expired;

`ifdef STOPWATCH_LAP_EN
  logic          r_hold;
  logic [CW-1:0] r_lap;

  // Lap toggles a frozen snapshot; the live count keeps running underneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 1'b0;
      r_lap  <= {CW{1'b0}};
    end else if (w_cell_load) begin
      r_hold <= 1'b0;
    end else if (lap && (r_state != DONE)) begin
      if (r_hold) begin
        r_hold <= 1'b0;
      end else begin
        r_hold <= 1'b1;
        r_lap  <= w_count;
      end
    end
  end

  assign digits = r_hold ? r_lap : w_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign digits       = w_count;
`endif

endmodule

// File: tb/tb_stopwatch_updown_gen.sv
// Randomised bench for stopwatch_updown_gen: two instances (stop-at-zero and wrap-down)
// checked every cycle against a count-in-tenths reference model.
module tb_stopwatch_updown_gen;

  localparam int DVSR       = 4;
  localparam int MIN_DIGITS = 1;
  localparam int MAXV       = 5999;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clr = 1'b0, dir = 1'b0, load = 1'b0, lap = 1'b0;
  logic [15:0] load_val = 16'd0;
  logic [15:0] digits0, digits1;
  logic        running0, running1, tick0, tick1, wrap0, wrap1, expired0, expired1;

  int n_vec = 0;
  int n_err = 0;

  int m_st [2];
  int m_presc [2];
  int m_val [2];
  int m_lap [2];
  bit m_exp [2];
  bit m_wrap [2];
  bit m_hold [2];

  always #5 clk = ~clk;

  stopwatch_updown_gen #(.DVSR(DVSR), .MIN_DIGITS(MIN_DIGITS), .WRAP_DOWN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .dir(dir),
    .load(load), .load_val(load_val), .lap(lap), .digits(digits0), .running(running0),
    .tick(tick0), .wrap(wrap0), .expired(expired0));

  stopwatch_updown_gen #(.DVSR(DVSR), .MIN_DIGITS(MIN_DIGITS), .WRAP_DOWN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .dir(dir),
    .load(load), .load_val(load_val), .lap(lap), .digits(digits1), .running(running1),
    .tick(tick1), .wrap(wrap1), .expired(expired1));

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 600 % 10), 4'(v / 100 % 6), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_dig(logic [3:0] d, int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  function automatic int from_bcd_sat(logic [15:0] b);
    return sat_dig(b[3:0], 9) + 10 * sat_dig(b[7:4], 9) + 100 * sat_dig(b[11:8], 5)
         + 600 * sat_dig(b[15:12], 9);
  endfunction

  function automatic logic [15:0] g_dig(int k);  return (k == 0) ? digits0 : digits1; endfunction
  function automatic logic [15:0] g_run(int k);  return {15'd0, (k == 0) ? running0 : running1}; endfunction
  function automatic logic [15:0] g_tick(int k); return {15'd0, (k == 0) ? tick0 : tick1}; endfunction
  function automatic logic [15:0] g_wrap(int k); return {15'd0, (k == 0) ? wrap0 : wrap1}; endfunction
  function automatic logic [15:0] g_exp(int k);  return {15'd0, (k == 0) ? expired0 : expired1}; endfunction

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_presc[k] = 0; m_val[k] = 0; m_lap[k] = 0;
      m_exp[k] = 1'b0; m_wrap[k] = 1'b0; m_hold[k] = 1'b0;
    end
  endtask

  // Expected outputs follow from model state: 0=idle, 1=run, 2=done.
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check("digits", k, g_dig(k), m_hold[k] ? to_bcd(m_lap[k]) : to_bcd(m_val[k]));
      check("running", k, g_run(k), {15'd0, m_st[k] == 1});
      check("tick", k, g_tick(k), {15'd0, (m_st[k] == 1) && (m_presc[k] == DVSR - 1)});
      check("wrap", k, g_wrap(k), {15'd0, m_wrap[k]});
      check("expired", k, g_exp(k), {15'd0, m_exp[k]});
    end
  endtask

  // Advance the model by one clock using the inputs currently applied; instance k wraps down iff k==1.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int st, old;
      bit tk, expn;
      st = m_st[k];
      old = m_val[k];
      tk = (st == 1) && (m_presc[k] == DVSR - 1);
      expn = 1'b0;
      m_wrap[k] = 1'b0;
      if (clr || load) begin
        m_val[k] = clr ? 0 : from_bcd_sat(load_val);
        m_presc[k] = 0; m_exp[k] = 1'b0; m_hold[k] = 1'b0;
        if (st == 2) m_st[k] = 0;
      end else begin
        if (tk) begin
          if (!dir) begin
            if (old == MAXV) begin m_val[k] = 0; m_wrap[k] = 1'b1; end
            else m_val[k] = old + 1;
          end else if (k == 1) begin
            if (old == 0) begin m_val[k] = MAXV; m_wrap[k] = 1'b1; end
            else m_val[k] = old - 1;
          end else begin
            if (old <= 1) begin m_val[k] = 0; m_exp[k] = 1'b1; expn = 1'b1; end
            else m_val[k] = old - 1;
          end
        end
        if (st == 1) m_presc[k] = tk ? 0 : m_presc[k] + 1;
        if (expn) m_st[k] = 2;
        else if (stop) begin
          if (st == 1) m_st[k] = 0;
        end else if (start) begin
          if (st == 0 || (st == 2 && old != 0)) m_st[k] = 1;
        end
        if (LAP_EN && lap && st != 2) begin
          if (m_hold[k]) m_hold[k] = 1'b0;
          else begin m_hold[k] = 1'b1; m_lap[k] = old; end
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    start = 1'b0; stop = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int n_tk;
    model_reset();
    #12;
    compare_all();
    for (int k = 0; k < 2; k++) check("reset_digits", k, g_dig(k), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up: one tick per DVSR cycles.
    start = 1'b1; cyc();
    n_tk = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (tick0) n_tk++;
    end
    check("up_tick_count", 0, 16'(n_tk), 16'd4);
    check("up_4_ticks", 0, digits0, 16'h0004);
    load = 1'b1; load_val = 16'h9599; cyc();
    run_n(4);
    check("up_wrap_digits", 0, digits0, 16'h0000);
    check("up_wrap_pulse", 0, g_wrap(0), 16'd1);

    // Count down from 1.0 s.
    stop = 1'b1; cyc();
    dir = 1'b1; load = 1'b1; load_val = 16'h0010; cyc();
    start = 1'b1; cyc();
    run_n(40);
    check("down_zero", 0, digits0, 16'h0000);
    check("down_expired", 0, g_exp(0), 16'd1);
    check("down_stopped", 0, g_run(0), 16'd0);
    check("down_zero_wrapmode", 1, digits1, 16'h0000);
    start = 1'b1; cyc();
    run_n(3);
    check("done_ignores_start", 0, g_run(0), 16'd0);
    check("down_wrap_digits", 1, digits1, 16'h9599);
    check("down_wrap_pulse", 1, g_wrap(1), 16'd1);
    check("down_wrap_no_expire", 1, g_exp(1), 16'd0);

    // clr outranks load and start; RUN is kept and the prescaler restarts.
    clr = 1'b1; load = 1'b1; load_val = 16'h1234; start = 1'b1; cyc();
    check("prio_digits", 1, digits1, 16'h0000);
    check("prio_running", 1, g_run(1), 16'd1);
    check("prio_done_to_idle", 0, g_run(0), 16'd0);
    run_n(3);
    check("prio_presc_restart", 1, g_tick(1), 16'd1);

    // Saturating load, then asynchronous reset between edges.
    dir = 1'b0; load = 1'b1; load_val = 16'hFAFF; cyc();
    check("sat_load", 0, digits0, 16'h9599);
    check("sat_load", 1, digits1, 16'h9599);
    start = 1'b1; cyc();
    run_n(2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_rst_digits", k, g_dig(k), 16'h0000);
      check("async_rst_running", k, g_run(k), 16'd0);
      check("async_rst_flags", k, g_tick(k) | g_wrap(k) | g_exp(k), 16'd0);
    end
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef STOPWATCH_LAP_EN
    load = 1'b1; load_val = 16'h0012; cyc();
    start = 1'b1; cyc();
    lap = 1'b1; cyc();
    run_n(19);
    check("lap_hold", 0, digits0, 16'h0012);
    lap = 1'b1; cyc();
    check("lap_release", 0, digits0, 16'h0017);
`endif

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      clr   = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 3);
      stop  = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 10);
      lap   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) dir = ~dir;
      load_val = 16'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_updown_gen.md
Name: stopwatch_updown_gen

Overview:
Parametrised up/down stopwatch and countdown timer. It counts a mixed-radix BCD time value (tenths, seconds-units, seconds-tens, then N decimal minute digits) on a prescaled tick. It adds a run/stop state machine, preload, expiry detection and lap hold. It sits between the debounced button logic and the seven-segment multiplexer and drives its digit bus directly.

Parameters:
DVSR, 10000000, prescaler period in clk cycles per 0.1 s tick (>=2)
MIN_DIGITS, 1, number of decimal minute digits (1..4)
NDIG, MIN_DIGITS+3, total digit count (derived, not overridden)
WRAP_DOWN, 0, 1 = countdown wraps from all-zero to max; 0 = stops and expires at zero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; enter RUN
stop  in  1  single-cycle pulse; enter IDLE (pause)
clr  in  1  synchronous clear of count, prescaler and flags
dir  in  1  0 = count up, 1 = count down; sampled on every tick
load  in  1  single-cycle pulse; load load_val into count
load_val  in  4*NDIG  BCD preload, digit 0 (tenths) in [3:0]
lap  in  1  single-cycle pulse; toggle lap hold (feature-gated)
digits  out  4*NDIG  displayed BCD value, digit 0 in [3:0]
running  out  1  high in RUN
tick  out  1  one-cycle pulse per counted 0.1 s
wrap  out  1  one-cycle pulse when count wraps (up past max, or down past zero with WRAP_DOWN=1)
expired  out  1  sticky; set when countdown reaches zero with WRAP_DOWN=0

Behaviour:
- Reset (rst_n low, asynchronous): count = 0, prescaler = 0, state IDLE, digits = 0, running/tick/wrap/expired = 0, lap hold cleared.
- Digit radices: d0 = 10, d1 = 10, d2 = 6, d3..d(NDIG-1) = 10. Max value is 9..9 5 9 9.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> DONE when a down tick produces all-zero and WRAP_DOWN=0.
  - DONE -> IDLE on clr or load. DONE -> RUN on start only if count is non-zero, otherwise remain in DONE.
- Input priority within a cycle: clr > load > stop > start.
  - clr: count = 0, prescaler = 0, expired = 0, lap hold released. The state is preserved except DONE, which goes to IDLE.
  - load: count = load_val, prescaler = 0, expired = 0. The state is preserved except DONE, which goes to IDLE.
  - Illegal load digits are saturated per digit: >9 becomes 9; d2 >5 becomes 5.
- Prescaler: counts 0..DVSR-1 only in RUN and holds otherwise. When it equals DVSR-1, it returns to 0 and tick pulses in the same cycle.
- Count update: the count updates on the clock edge following the tick cycle, so the count is registered one cycle after tick.
- Up count: ripple-carry increment. From max, all digits go to 0 and wrap pulses.
- Down count: ripple-borrow decrement.
  - From 0 with WRAP_DOWN=1: all digits go to max and wrap pulses.
  - When a tick reaches 0 with WRAP_DOWN=0: expired is set, the FSM enters DONE and running drops on the next cycle.
  - A tick at count 0 in RUN with WRAP_DOWN=0 (start issued at zero) is a no-op and expires immediately.
- dir change mid-run: takes effect on the next tick. There is no prescaler reset.
- Simultaneous tick and stop: the tick is still counted. stop applies to the next prescaler cycle.
- tick, wrap: one-cycle pulses, low outside RUN.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined: a lap pulse in RUN or IDLE copies the live count into a lap register and sets hold; digits shows the lap register while counting continues internally. The next lap pulse releases hold. clr, load and reset release hold.
- Undefined: no lap register is built, the lap input is ignored and digits always equals the live count.

Decomposition:
- Package stopwatch_pkg: state enum (IDLE/RUN/DONE), radix constants (RADIX_DEC=10, RADIX_SEC_TENS=6), and a function returning the radix for digit index i.
- Sub-module bcd_digit_cell: parameter RADIX.
  - Inputs: inc, dec, carry/borrow in, load and load value.
  - Outputs: digit, carry_out, borrow_out.
  - Instantiated NDIG times in a generate loop.

Test Plan:
1. DVSR=4, MIN_DIGITS=1, up. Apply start, run 4 ticks -> tick every 4 cycles and digits 0x0004. Load 0x9599, tick -> digits 0x0000 with wrap pulse.
2. Down, WRAP_DOWN=0. Load 0x0010, start, run 10 ticks -> digits 0x0000, expired=1, running=0. Further start -> remains DONE.
3. Down, WRAP_DOWN=1. Load 0x0001, start, 2 ticks -> 0x0000, then 0x9599 with wrap pulse and expired=0.
4. Priority: assert clr, load and start in the same cycle during RUN -> count 0x0000, prescaler 0, state RUN.
5. Illegal load of 0xFAFF -> digits 0x9599. Assert rst_n low mid-run, asynchronously -> all outputs 0 within the same cycle.
6. With STOPWATCH_LAP_EN: lap at 0x0012, 5 more ticks -> digits stays 0x0012. Lap again -> digits 0x0017.
